// File: rtl/lzc_normalizer.sv
// Two-stage mantissa normalizer: shifts out leading positions limited by the exponent,
// with valid/ready flow control on both sides and a saturating underflow counter.
module lzc_normalizer #(
    parameter int MANT_W = 6,
    parameter int CNT_W  = 3,
    parameter int EXP_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] in_mant,
    input  logic [CNT_W-1:0]  in_cnt,
    input  logic [EXP_W-1:0]  in_exp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] out_mant,
    output logic [EXP_W-1:0]  out_exp,
    output logic              out_zero,
    output logic              out_uflow,
    output logic [7:0]        uflow_cnt
);

    localparam int SH_W  = $clog2(MANT_W + 1);
    localparam int MAX_A = (CNT_W > EXP_W) ? CNT_W : EXP_W;
    localparam int CMP_W = (MAX_A > SH_W) ? MAX_A : SH_W;

    // Returns {uflow, sh}: sh = min(cnt, MANT_W, exp); uflow when the exponent is the binding limit.
    function automatic logic [SH_W:0] clamp_shift(input logic [CNT_W-1:0] cnt,
                                                   input logic [EXP_W-1:0] e_in);
        logic [CMP_W-1:0] c;
        logic [CMP_W-1:0] e;
        logic [CMP_W-1:0] lim;
        logic [CMP_W-1:0] cc;
        logic [CMP_W-1:0] s;
        logic             uf;
        c   = CMP_W'(cnt);
        e   = CMP_W'(e_in);
        lim = CMP_W'(MANT_W);
        cc  = (c > lim) ? lim : c;
        uf  = (cc > e);
        s   = uf ? e : cc;
        return {uf, SH_W'(s)};
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic              vld_p1;
    logic [MANT_W-1:0] mant_p1;
    logic [EXP_W-1:0]  exp_p1;
    logic [SH_W-1:0]   sh_p1;
    logic              uflow_p1;

    logic              vld_p2;
    logic [MANT_W-1:0] mant_p2;
    logic [EXP_W-1:0]  exp_p2;
    logic              zero_p2;
    logic              uflow_p2;
    logic [7:0]        ucnt_q;

    logic              adv_p1;
    logic              adv_p2;
    logic [SH_W:0]     clamp_p0;
    logic [MANT_W-1:0] shifted_p1;

    assign adv_p2     = !vld_p2 || out_ready;
    assign adv_p1     = !vld_p1 || adv_p2;
    assign in_ready   = adv_p1;
    assign clamp_p0   = clamp_shift(in_cnt, in_exp);
    assign shifted_p1 = mant_p1 << sh_p1;

    // Stage 1: register clamped shift amount and underflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (adv_p1) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && adv_p1) begin
            mant_p1  <= in_mant;
            exp_p1   <= in_exp;
            sh_p1    <= clamp_p0[SH_W-1:0];
            uflow_p1 <= clamp_p0[SH_W];
        end
    end

    // Stage 2: register shifted mantissa and adjusted exponent
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2   <= 1'b0;
            mant_p2  <= '0;
            exp_p2   <= '0;
            zero_p2  <= 1'b0;
            uflow_p2 <= 1'b0;
        end else if (adv_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                mant_p2  <= shifted_p1;
                exp_p2   <= exp_p1 - EXP_W'(sh_p1);
                zero_p2  <= (shifted_p1 == '0);
                uflow_p2 <= uflow_p1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ucnt_q <= 8'd0;
        end else if (vld_p2 && out_ready && uflow_p2) begin
            ucnt_q <= sat_inc(ucnt_q);
        end
    end

    assign out_valid = vld_p2;
    assign out_mant  = mant_p2;
    assign out_exp   = exp_p2;
    assign out_zero  = zero_p2;
    assign out_uflow = uflow_p2;
    assign uflow_cnt = ucnt_q;

endmodule

// File: tb/tb_lzc_normalizer.sv
// Directed bench for lzc_normalizer: vector table plus backpressure, reset and saturation sequences.
module tb_lzc_normalizer;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] in_mant;
    logic [2:0] in_cnt;
    logic [7:0] in_exp;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_mant;
    logic [7:0] out_exp;
    logic       out_zero;
    logic       out_uflow;
    logic [7:0] uflow_cnt;

    int checks = 0;
    int errors = 0;
    int ucnt_m = 0;

    typedef struct {
        logic [5:0] mant;
        logic [2:0] cnt;
        logic [7:0] ex;
        logic [5:0] o_mant;
        logic [7:0] o_exp;
        logic       o_zero;
        logic       o_uflow;
    } vec_t;

    vec_t vecs[9];

    lzc_normalizer #(.MANT_W(6), .CNT_W(3), .EXP_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mant   (in_mant),
        .in_cnt    (in_cnt),
        .in_exp    (in_exp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mant  (out_mant),
        .out_exp   (out_exp),
        .out_zero  (out_zero),
        .out_uflow (out_uflow),
        .uflow_cnt (uflow_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] m, input logic [2:0] c, input logic [7:0] e);
        in_valid = 1'b1;
        in_mant  = m;
        in_cnt   = c;
        in_exp   = e;
    endtask

    task automatic check_out(input string tag, input logic [5:0] m, input logic [7:0] e,
                             input logic z, input logic u);
        check({tag, " valid"}, 32'(out_valid), 32'd1);
        check({tag, " mant"},  32'(out_mant),  32'(m));
        check({tag, " exp"},   32'(out_exp),   32'(e));
        check({tag, " zero"},  32'(out_zero),  32'(z));
        check({tag, " uflow"}, 32'(out_uflow), 32'(u));
    endtask

    initial begin
        vecs[0] = '{6'b001011, 3'd2, 8'd10,  6'b101100, 8'd8,   1'b0, 1'b0};
        vecs[1] = '{6'b000001, 3'd5, 8'd3,   6'b001000, 8'd0,   1'b0, 1'b1};
        vecs[2] = '{6'b000000, 3'd7, 8'd20,  6'b000000, 8'd14,  1'b1, 1'b0};
        vecs[3] = '{6'b100000, 3'd0, 8'd5,   6'b100000, 8'd5,   1'b0, 1'b0};
        vecs[4] = '{6'b000011, 3'd4, 8'd4,   6'b110000, 8'd0,   1'b0, 1'b0};
        vecs[5] = '{6'b000011, 3'd4, 8'd0,   6'b000011, 8'd0,   1'b0, 1'b1};
        vecs[6] = '{6'b000001, 3'd6, 8'd200, 6'b000000, 8'd194, 1'b1, 1'b0};
        vecs[7] = '{6'b000101, 3'd7, 8'd2,   6'b010100, 8'd0,   1'b0, 1'b1};
        vecs[8] = '{6'b111111, 3'd3, 8'd255, 6'b111000, 8'd252, 1'b0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_mant = '0; in_cnt = '0; in_exp = '0; out_ready = 1'b1;
        #12;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst in_ready",  32'(in_ready),  32'd1);
        check("rst out_mant",  32'(out_mant),  32'd0);
        check("rst out_exp",   32'(out_exp),   32'd0);
        check("rst out_zero",  32'(out_zero),  32'd0);
        check("rst out_uflow", 32'(out_uflow), 32'd0);
        check("rst uflow_cnt", 32'(uflow_cnt), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        step();

        // Single beats through the table, one at a time
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].mant, vecs[i].cnt, vecs[i].ex);
            check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'd1);
            step();
            in_valid = 1'b0;
            check($sformatf("v%0d early valid", i), 32'(out_valid), 32'd0);
            step();
            check_out($sformatf("v%0d", i), vecs[i].o_mant, vecs[i].o_exp,
                      vecs[i].o_zero, vecs[i].o_uflow);
            step();
            if (vecs[i].o_uflow) ucnt_m++;
            check($sformatf("v%0d drained", i), 32'(out_valid), 32'd0);
            check($sformatf("v%0d uflow_cnt", i), 32'(uflow_cnt), 32'(ucnt_m));
        end

        // Backpressure: A and B fill both stages, C waits, then drain in order
        out_ready = 1'b0;
        drive(6'b001011, 3'd2, 8'd10);
        check("bp A in_ready", 32'(in_ready), 32'd1);
        step();
        drive(6'b000001, 3'd5, 8'd3);
        check("bp B in_ready", 32'(in_ready), 32'd1);
        step();
        drive(6'b000011, 3'd4, 8'd4);
        check("bp full in_ready", 32'(in_ready), 32'd0);
        check_out("bp hold0", 6'b101100, 8'd8, 1'b0, 1'b0);
        step();
        step();
        check("bp held in_ready", 32'(in_ready), 32'd0);
        check_out("bp hold2", 6'b101100, 8'd8, 1'b0, 1'b0);
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check_out("bp B", 6'b001000, 8'd0, 1'b0, 1'b1);
        step();
        ucnt_m++;
        check_out("bp C", 6'b110000, 8'd0, 1'b0, 1'b0);
        check("bp ucnt", 32'(uflow_cnt), 32'(ucnt_m));
        step();
        check("bp empty", 32'(out_valid), 32'd0);

        // Reset with both stages occupied
        out_ready = 1'b0;
        drive(6'b000001, 3'd5, 8'd3);
        step();
        drive(6'b001011, 3'd2, 8'd10);
        step();
        in_valid = 1'b0;
        check("mid full valid", 32'(out_valid), 32'd1);
        check("mid full in_ready", 32'(in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        ucnt_m = 0;
        check("mid rst out_valid", 32'(out_valid), 32'd0);
        check("mid rst uflow_cnt", 32'(uflow_cnt), 32'd0);
        check("mid rst in_ready",  32'(in_ready),  32'd1);
        check("mid rst out_mant",  32'(out_mant),  32'd0);
        @(negedge clk) rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        check("post rst empty", 32'(out_valid), 32'd0);
        drive(6'b100000, 3'd0, 8'd5);
        step();
        in_valid = 1'b0;
        check("post rst lat1", 32'(out_valid), 32'd0);
        step();
        check_out("post rst", 6'b100000, 8'd5, 1'b0, 1'b0);
        step();
        check("post rst drained", 32'(out_valid), 32'd0);

        // Saturation: 260 back-to-back underflow beats
        for (int i = 0; i < 260; i++) begin
            drive(6'b000001, 3'd5, 8'd3);
            if (!in_ready) begin
                checks++; errors++;
                $display("FAIL sat in_ready: got 0 expected 1 at beat %0d", i);
            end
            step();
            if (i == 99) check("sat mid count", 32'(uflow_cnt), 32'd98);
        end
        in_valid = 1'b0;
        step();
        step();
        step();
        check("sat count", 32'(uflow_cnt), 32'd255);
        check("sat empty", 32'(out_valid), 32'd0);
        drive(6'b000001, 3'd5, 8'd3);
        step();
        in_valid = 1'b0;
        step();
        check_out("sat extra", 6'b001000, 8'd0, 1'b0, 1'b1);
        step();
        check("sat hold", 32'(uflow_cnt), 32'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lzc_normalizer.md
LZC_NORMALIZER -- requirements
Module: lzc_normalizer

Interface
REQ-001 The block SHALL have parameter MANT_W, default 6, meaning the mantissa width.
REQ-002 The block SHALL have parameter CNT_W, default 3, meaning the width of the leading-count field; the count comes from the leading-count encoder.
REQ-003 The block SHALL have parameter EXP_W, default 8, meaning the exponent width.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit, meaning an input beat is present.
REQ-007 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts a beat this cycle.
REQ-008 The block SHALL have port in_mant, input, MANT_W bits, the unnormalized mantissa.
REQ-009 The block SHALL have port in_cnt, input, CNT_W bits, the leading-position count to shift out.
REQ-010 The block SHALL have port in_exp, input, EXP_W bits, the unsigned biased exponent.
REQ-011 The block SHALL have port out_valid, output, 1 bit, meaning a result beat is present.
REQ-012 The block SHALL have port out_ready, input, 1 bit, meaning the consumer accepts the result this cycle.
REQ-013 The block SHALL have port out_mant, output, MANT_W bits, the normalized mantissa.
REQ-014 The block SHALL have port out_exp, output, EXP_W bits, the adjusted exponent.
REQ-015 The block SHALL have port out_zero, output, 1 bit, asserted when out_mant is all zeros.
REQ-016 The block SHALL have port out_uflow, output, 1 bit, asserted when the shift was limited by the exponent.
REQ-017 The block SHALL have port uflow_cnt, output, 8 bits, a saturating count of delivered underflow beats.

Function
REQ-018 The block SHALL accept an input beat when in_valid and in_ready are both 1, and SHALL deliver an output beat when out_valid and out_ready are both 1.
REQ-019 The block SHALL be a two-stage pipeline: S1 registers the clamped shift amount, S2 registers the shifted result.
- Latency: 2 cycles from acceptance to out_valid when out_ready is held at 1.
- Throughput: 1 beat per cycle.
REQ-020 S1 SHALL compute the shift amount as sh = min(in_cnt, MANT_W, in_exp).
REQ-021 S1 SHALL set the underflow flag to 1 when min(in_cnt, MANT_W) > in_exp.
REQ-022 S2 SHALL compute out_mant = mant << sh with zero fill; a shift of MANT_W SHALL yield zero.
REQ-023 S2 SHALL compute out_exp = exp - sh; this value is never negative by construction.
REQ-024 S2 SHALL compute out_zero = (out_mant == 0), independent of out_uflow.
REQ-025 Each stage SHALL advance when it is empty or when the stage downstream of it advances; S2 advances when out_valid is 0 or out_ready is 1.
REQ-026 in_ready SHALL be 1 exactly when S1 can advance this cycle; in_ready SHALL be combinational from stage state and out_ready only, with no path from in_valid.
REQ-027 While out_valid is 1 and out_ready is 0, out_mant, out_exp, out_zero and out_uflow SHALL remain stable.
REQ-028 Under backpressure, S1 SHALL hold its contents, and in_ready SHALL drop only when both stages are full.
REQ-029 Beats SHALL be neither dropped, duplicated nor reordered.
REQ-030 When a beat is accepted and another delivered in the same cycle with both stages full, the pipeline SHALL shift by one with no bubble.
REQ-031 uflow_cnt SHALL increment on each delivered beat (out_valid and out_ready both 1) with out_uflow set, SHALL saturate at 255, and SHALL NOT wrap.
REQ-032 in_cnt values above MANT_W (possible for CNT_W wider than needed) SHALL be clamped per REQ-020 and SHALL NOT be flagged as underflow unless the exponent limits the shift.

Reset
REQ-033 While rst_n is 0, the block SHALL clear both stage valid bits immediately (asynchronously): out_valid = 0, in_ready = 1, out_mant = 0, out_exp = 0, out_zero = 0, out_uflow = 0, uflow_cnt = 0.
REQ-034 Reset mid-operation SHALL discard all in-flight beats; the first beat accepted after rst_n rises SHALL emerge with normal 2-cycle latency.

Verification (MANT_W=6, CNT_W=3, EXP_W=8)
REQ-035 Normal shift: in_mant=001011, in_cnt=2, in_exp=10, out_ready=1 -> 2 cycles later out_mant=101100, out_exp=8, out_zero=0, out_uflow=0.
REQ-036 Exponent limit: in_mant=000001, in_cnt=5, in_exp=3 -> out_mant=001000, out_exp=0, out_uflow=1, uflow_cnt 0 to 1 on delivery.
REQ-037 Over-range count: in_mant=000000, in_cnt=7, in_exp=20 -> sh=6, out_mant=000000, out_exp=14, out_zero=1, out_uflow=0.
REQ-038 Backpressure: send beats A, B, C back-to-back with out_ready=0 -> in_ready=0 after A and B are accepted, C waits, outputs hold A stable; releasing out_ready delivers A, B, C in order with one per cycle.
REQ-039 Reset mid-flight: assert rst_n=0 with both stages valid -> out_valid=0 and uflow_cnt=0 within the same cycle; after release, a new beat is delivered 2 cycles after acceptance.
REQ-040 Saturation: deliver 260 underflow beats -> uflow_cnt reads 255 and stays at 255.
